// File: rtl/sme_stream_loader.sv
// Buffers one framed string/pattern record from a ready/valid byte stream and replays it
// to the string-match engine, holding off new records until the SME reports a result.
module sme_stream_loader #(
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       err_order,
    output logic       err_len,
    output logic       err_timeout,
    output logic [7:0] pat_count
);

    localparam int LW = $clog2(MAX_STR + 1);
    localparam int AW = (MAX_STR > 1) ? $clog2(MAX_STR) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_SEND_STR, S_SEND_PAT, S_WAIT_RES
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_kind;
    logic          r_ovf;
    logic          r_str_loaded;
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic [LW-1:0] r_len;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_pat_count;
    logic [7:0]    r_buf [MAX_STR];

    logic          w_ready;
    logic          w_accept;
    logic          w_kind;
    logic [LW-1:0] w_max;
    logic          w_full;
    logic [LW-1:0] w_len;
    logic          w_rec_end;
    logic          w_drop;
    logic          w_send_done;
    logic          w_tmo_hit;

    // Ready is gated by the reset pin so it reads 0 throughout reset and 1 as soon as it lifts.
    assign w_ready     = reset && (r_state == S_IDLE || r_state == S_FILL);
    assign w_accept    = in_valid && w_ready;
    assign w_kind      = (r_state == S_IDLE) ? in_kind : r_kind;
    assign w_max       = w_kind ? LW'(MAX_PAT) : LW'(MAX_STR);
    assign w_full      = (r_wr_ptr == w_max);
    assign w_len       = w_full ? r_wr_ptr : r_wr_ptr + 1'b1;
    assign w_rec_end   = w_accept && in_last;
    assign w_drop      = w_rec_end && w_kind && !r_str_loaded;
    assign w_send_done = (r_rd_ptr == r_len - 1'b1);
    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_FILL: begin
                if (w_rec_end)     w_next = w_drop ? S_IDLE : (w_kind ? S_SEND_PAT : S_SEND_STR);
                else if (w_accept) w_next = S_FILL;
            end
            S_SEND_STR: if (w_send_done) w_next = S_IDLE;
            S_SEND_PAT: if (w_send_done) w_next = S_WAIT_RES;
            S_WAIT_RES: if (sme_valid || w_tmo_hit) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = w_ready;
        busy        = (r_state != S_IDLE);
        isstring    = (r_state == S_SEND_STR);
        ispattern   = (r_state == S_SEND_PAT);
        chardata    = (isstring || ispattern) ? r_buf[r_rd_ptr[AW-1:0]] : 8'd0;
        err_len     = w_rec_end && (r_ovf || w_full);
        err_order   = w_drop;
        err_timeout = (r_state == S_WAIT_RES) && w_tmo_hit && !sme_valid;
        pat_count   = r_pat_count;
    end

    // Write side: pointer saturates at the record's limit, overflow remembered for err_len.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kind   <= 1'b0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_len    <= '0;
        end else if (w_accept) begin
            if (r_state == S_IDLE) r_kind <= in_kind;
            if (in_last) begin
                r_wr_ptr <= '0;
                r_ovf    <= 1'b0;
                r_len    <= w_len;
            end else if (w_full) begin
                r_ovf    <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !w_full) r_buf[r_wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr     <= '0;
            r_tmo        <= '0;
            r_str_loaded <= 1'b0;
            r_pat_count  <= 8'd0;
        end else begin
            r_rd_ptr <= ((r_state == S_SEND_STR || r_state == S_SEND_PAT) && !w_send_done)
                        ? r_rd_ptr + 1'b1 : '0;
            r_tmo    <= (r_state == S_WAIT_RES) ? r_tmo + 1'b1 : '0;
            if (r_state == S_SEND_STR && w_send_done) begin
                r_str_loaded <= 1'b1;
                r_pat_count  <= 8'd0;
            end
            if (r_state == S_SEND_PAT && w_send_done) r_pat_count <= r_pat_count + 8'd1;
            if (err_timeout) r_str_loaded <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sme_stream_loader.sv
// Randomized self-checking bench for sme_stream_loader; a record-level model predicts the
// replayed bytes, error pulses, string-loaded state and pattern count.
module tb_sme_stream_loader;

    localparam int MAX_STR = 32;
    localparam int MAX_PAT = 8;
    localparam int TIMEOUT = 64;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_kind = 1'b0;
    logic       in_last = 1'b0;
    logic       sme_valid = 1'b0;
    logic       in_ready, isstring, ispattern, busy, err_order, err_len, err_timeout;
    logic [7:0] chardata, pat_count;

    int checks = 0;
    int errors = 0;
    bit m_loaded = 0;
    int m_pat = 0;

    sme_stream_loader #(.MAX_STR(MAX_STR), .MAX_PAT(MAX_PAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_kind(in_kind), .in_last(in_last),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .busy(busy), .err_order(err_order), .err_len(err_len),
        .err_timeout(err_timeout), .pat_count(pat_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; in_last = 0; sme_valid = 0;
        reset = 0;
        @(negedge clk);
        reset = 1;
        m_loaded = 0;
        m_pat = 0;
    endtask

    task automatic send_record(input bit kind, input byte_q_t data, input bit noise,
                               output bit e_len, output bit e_order);
        e_len = 0;
        e_order = 0;
        for (int i = 0; i < data.size(); i++) begin
            @(negedge clk);
            in_valid  = 1;
            in_kind   = (i == 0) ? kind : ~kind;
            in_data   = data[i];
            in_last   = (i == data.size() - 1);
            sme_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL in_ready_fill got %0b exp 1", in_ready);
            end
            if (in_last) begin
                e_len = err_len;
                e_order = err_order;
            end else begin
                checks++;
                if ({err_len, err_order} !== 2'b00) begin
                    errors++; $display("FAIL early_err got %b exp 00", {err_len, err_order});
                end
            end
        end
    endtask

    task automatic collect(output byte_q_t q, output bit got_s, output bit got_p,
                           output bit first);
        q = {};
        got_s = 0; got_p = 0; first = 0;
        for (int c = 0; c < MAX_STR + 4; c++) begin
            @(negedge clk);
            in_valid = 0; in_last = 0; sme_valid = 0;
            #1;
            checks++;
            if (isstring && ispattern) begin
                errors++; $display("FAIL strobe_excl got both high exp one");
            end
            if (isstring || ispattern) begin
                if (c == 0) first = 1;
                if (isstring) got_s = 1;
                if (ispattern) got_p = 1;
                q.push_back(chardata);
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL ready_while_send got %0b exp 0", in_ready);
                end
            end else begin
                checks++;
                if (chardata !== 8'd0) begin
                    errors++; $display("FAIL chardata_idle got %0h exp 0", chardata);
                end
                break;
            end
        end
    endtask

    // resp_delay < 0 means the SME never answers.
    task automatic run_record(input bit kind, input byte_q_t data, input int resp_delay,
                              input bit noise);
        bit e_len, e_order, got_s, got_p, first, exp_drop;
        byte_q_t q;
        int lim, exp_n;
        lim = kind ? MAX_PAT : MAX_STR;
        exp_n = (data.size() > lim) ? lim : data.size();
        exp_drop = kind && !m_loaded;
        send_record(kind, data, noise, e_len, e_order);
        collect(q, got_s, got_p, first);
        checks++;
        if (e_len !== (data.size() > lim)) begin
            errors++; $display("FAIL err_len got %0b exp %0b", e_len, data.size() > lim);
        end
        checks++;
        if (e_order !== exp_drop) begin
            errors++; $display("FAIL err_order got %0b exp %0b", e_order, exp_drop);
        end
        if (exp_drop) begin
            checks++;
            if (q.size() != 0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL drop got n=%0d busy=%0b rdy=%0b exp 0 0 1",
                                   q.size(), busy, in_ready);
            end
            return;
        end
        checks++;
        if (first !== 1'b1 || got_s !== !kind || got_p !== kind) begin
            errors++; $display("FAIL strobe_kind got first=%0b s=%0b p=%0b exp 1 %0b %0b",
                               first, got_s, got_p, !kind, kind);
        end
        checks++;
        if (q.size() != exp_n) begin
            errors++; $display("FAIL stream_len got %0d exp %0d", q.size(), exp_n);
        end
        for (int i = 0; i < exp_n && i < q.size(); i++) begin
            checks++;
            if (q[i] !== data[i]) begin
                errors++; $display("FAIL stream_byte[%0d] got %0h exp %0h", i, q[i], data[i]);
            end
        end
        if (!kind) begin
            m_loaded = 1;
            m_pat = 0;
            checks++;
            if (busy !== 1'b0 || pat_count !== 8'd0) begin
                errors++; $display("FAIL after_str got busy=%0b pc=%0d exp 0 0", busy, pat_count);
            end
            return;
        end
        m_pat = (m_pat + 1) % 256;
        checks++;
        if (busy !== 1'b1 || pat_count !== 8'(m_pat)) begin
            errors++; $display("FAIL wait_entry got busy=%0b pc=%0d exp 1 %0d", busy, pat_count, m_pat);
        end
        if (resp_delay >= 0) begin
            sme_valid = (resp_delay == 0);
            #1;
            for (int k = 1; k <= resp_delay; k++) begin
                checks++;
                if (err_timeout !== 1'b0) begin
                    errors++; $display("FAIL early_timeout got 1 exp 0 at k=%0d", k - 1);
                end
                @(negedge clk);
                sme_valid = (k == resp_delay);
                #1;
            end
            checks++;
            if (err_timeout !== 1'b0) begin
                errors++; $display("FAIL valid_wins got err_timeout=1 exp 0");
            end
            @(negedge clk);
            sme_valid = 0;
            #1;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL after_valid got rdy=%0b busy=%0b exp 1 0", in_ready, busy);
            end
        end else begin
            for (int k = 0; k < TIMEOUT; k++) begin
                if (k > 0) begin @(negedge clk); #1; end
                checks++;
                if (err_timeout !== (k == TIMEOUT - 1)) begin
                    errors++; $display("FAIL timeout_pulse got %0b exp %0b at k=%0d",
                                       err_timeout, k == TIMEOUT - 1, k);
                end
            end
            @(negedge clk); #1;
            checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL after_timeout got rdy=%0b busy=%0b exp 1 0", in_ready, busy);
            end
            m_loaded = 0;
        end
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
        return q;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, busy, isstring, ispattern, err_order, err_len, err_timeout} !== 7'd0 ||
            chardata !== 8'd0 || pat_count !== 8'd0) begin
            errors++; $display("FAIL reset_outputs got rdy=%0b busy=%0b cd=%0h pc=%0d exp all 0",
                               in_ready, busy, chardata, pat_count);
        end
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%0b busy=%0b exp 1 0", in_ready, busy);
        end
    endtask

    task automatic test_string();
        byte_q_t d;
        d = {8'h41, 8'h42, 8'h43, 8'h44};
        run_record(0, d, 0, 0);
    endtask

    task automatic test_pattern();
        byte_q_t d;
        d = {8'h42, 8'h5e, 8'h43};
        run_record(1, d, 5, 0);
    endtask

    task automatic test_order();
        do_reset();
        run_record(1, rand_bytes(3), 0, 0);
    endtask

    task automatic test_len();
        run_record(0, rand_bytes(35), 0, 0);
        run_record(1, rand_bytes(10), 2, 0);
        run_record(1, rand_bytes(1), 0, 0);
    endtask

    task automatic test_tie();
        run_record(1, rand_bytes(4), TIMEOUT - 1, 0);
    endtask

    task automatic test_timeout();
        run_record(0, rand_bytes(5), 0, 0);
        run_record(1, rand_bytes(6), -1, 0);
        run_record(1, rand_bytes(2), 0, 0);
    endtask

    task automatic test_reset_mid();
        bit e_len, e_order;
        byte_q_t d;
        do_reset();
        d = rand_bytes(6);
        send_record(0, d, 0, e_len, e_order);
        @(negedge clk); in_valid = 0; in_last = 0; #1;
        @(negedge clk); #1;
        checks++;
        if (isstring !== 1'b1 || chardata !== d[1]) begin
            errors++; $display("FAIL mid_byte2 got s=%0b cd=%0h exp 1 %0h", isstring, chardata, d[1]);
        end
        #1 reset = 0;
        #1;
        checks++;
        if (isstring !== 1'b0 || chardata !== 8'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got s=%0b cd=%0h rdy=%0b busy=%0b exp 0 0 0 0",
                               isstring, chardata, in_ready, busy);
        end
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_release got rdy=%0b busy=%0b exp 1 0", in_ready, busy);
        end
        m_loaded = 0;
        m_pat = 0;
        run_record(1, rand_bytes(3), 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 40; r++) begin
            bit kind;
            int n, delay;
            kind  = ($urandom_range(0, 2) != 0);
            n     = kind ? $urandom_range(1, 12) : $urandom_range(1, 40);
            delay = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20);
            run_record(kind, rand_bytes(n), delay, 1);
        end
    endtask

    initial begin
        test_reset();
        test_string();
        test_pattern();
        test_order();
        test_string();
        test_len();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
